serial_comparator: RTL and testbench
====================================

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 SHALL have parameter W, default 8, operand width in bits; legal range W >= 2.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1 bit, request to begin a comparison.
REQ-005 SHALL have port a, input, W bits, first operand.
REQ-006 SHALL have port b, input, W bits, second operand.
REQ-007 SHALL have port signed_mode, input, 1 bit: 1 = two's-complement compare, 0 = unsigned.
REQ-008 SHALL have port busy, output, 1 bit, high while a comparison is in progress.
REQ-009 SHALL have port done, output, 1 bit, one-cycle pulse when a result is presented.
REQ-010 SHALL have ports gt, eq, lt, output, 1 bit each, the result flags (a>b, a==b, a<b).

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 In IDLE, start=1 at an edge SHALL latch a, b and signed_mode, set bit index to W-1 and enter RUN; busy SHALL rise after that edge.
REQ-013 start SHALL be ignored in RUN and DONE; a, b and signed_mode changes after latching SHALL have no effect.
REQ-014 RUN SHALL examine one latched bit pair per cycle, MSB first, decrementing the index.
REQ-015 In signed mode the MSB pair SHALL be evaluated with inverted sense (the operand with MSB=1 is smaller).
REQ-016 After bit 0 is examined with no difference, the FSM SHALL enter DONE with eq=1.
REQ-017 At the first differing bit the decision SHALL be fixed (gt or lt); later bits SHALL NOT alter it.
REQ-018 Entering DONE SHALL update gt/eq/lt with exactly one flag high; done=1 and busy=0 for exactly the DONE cycle; next edge SHALL return to IDLE.
REQ-019 Without early exit, done SHALL be high in the cycle after edge W counted from the start-sampling edge (edge 0); throughput is one result per W+2 cycles.
REQ-020 gt/eq/lt SHALL hold their last result through IDLE and the following RUN until the next DONE.
REQ-021 start asserted in the same cycle as DONE SHALL be ignored; it is accepted only once IDLE is re-entered.

Reset
REQ-022 reset_n=0 SHALL immediately force IDLE, busy=0, done=0, gt=0, eq=0, lt=0 and clear the latched operands and index, including mid-RUN; no done pulse SHALL follow.
REQ-023 After reset_n deassertion the first start in IDLE SHALL be accepted normally.

Configuration
REQ-024 Macro SERIAL_CMP_EARLY_EXIT_EN defined: RUN SHALL enter DONE at the edge examining the first differing bit i, so done is high after edge W-i.
REQ-025 Macro SERIAL_CMP_EARLY_EXIT_EN undefined: RUN SHALL always examine all W bits; done latency is fixed at W; results are identical in both builds.

Structure
REQ-026 Package serial_cmp_pkg SHALL hold the FSM state encodings and the result-code constants (GT, EQ, LT).
REQ-027 A combinational sub-module cmp_bit SHALL compute per-bit greater/less given a bit pair and an MSB-invert flag; the FSM, counter and result registers SHALL live in serial_comparator.

Verification (W=8 unless stated)
REQ-028 unsigned a=0xA5, b=0x5A -> gt=1, eq=0, lt=0; done after edge 8 (no macro) or edge 1 (macro).
REQ-029 a=b=0x3C, both modes -> eq=1; done after edge 8 in both builds.
REQ-030 a=0x80, b=0x7F: signed_mode=1 -> lt=1; signed_mode=0 -> gt=1.
REQ-031 start pulsed and a/b changed during RUN -> ignored; result matches the operands latched at edge 0; single done pulse.
REQ-032 reset_n low at edge 3 of a run -> all outputs 0 at once, no done; a new start after release completes correctly.
REQ-033 W=3, nested sweep of all a,b pairs in both modes -> every result matches a behavioural model, exactly one flag high each time.

Source files
------------

// File: rtl/serial_cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_cmp_pkg
//  Description : Shared definitions for the bit-serial magnitude comparator:
//                FSM state encoding and one-hot result codes {gt,eq,lt}.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Result codes, packed as {gt, eq, lt}
    localparam logic [2:0] RES_NONE = 3'b000;
    localparam logic [2:0] GT       = 3'b100;
    localparam logic [2:0] EQ       = 3'b010;
    localparam logic [2:0] LT       = 3'b001;

endpackage
`default_nettype wire

// File: rtl/cmp_bit.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_bit
//  Description : Combinational single-bit-pair comparison. With msb_inv set
//                (sign bit of a two's-complement compare) the sense is
//                inverted: the operand holding a 1 is the smaller one.
//  Ports       : a_bit, b_bit - bit pair under examination
//                msb_inv      - invert comparison sense
//                gt, lt       - a_bit greater / less than b_bit
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_bit (
    input  logic a_bit,
    input  logic b_bit,
    input  logic msb_inv,
    output logic gt,
    output logic lt
);

    logic w_a_hi;
    logic w_b_hi;

    assign w_a_hi = a_bit & ~b_bit;
    assign w_b_hi = ~a_bit & b_bit;

    assign gt = msb_inv ? w_b_hi : w_a_hi;
    assign lt = msb_inv ? w_a_hi : w_b_hi;

endmodule
`default_nettype wire

// File: rtl/serial_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : serial_comparator
//  Description : Bit-serial magnitude comparator, MSB first, one bit pair per
//                cycle. Supports unsigned and two's-complement operands.
//                Optional macro SERIAL_CMP_EARLY_EXIT_EN: finish at the first
//                differing bit instead of always scanning all W bits.
//  Ports       : clk, reset_n (async, active low)
//                start, a, b, signed_mode - request and operands (latched)
//                busy  - comparison in progress
//                done  - one-cycle result strobe
//                gt/eq/lt - held result flags, exactly one high after a run
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_comparator
    import serial_cmp_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         signed_mode,
    output logic         busy,
    output logic         done,
    output logic         gt,
    output logic         eq,
    output logic         lt
);

    localparam int              IW        = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0]   C_MSB_IDX = IW'(W - 1);

    state_t        r_state;
    state_t        w_next;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_sm;
    logic [IW-1:0] r_idx;
    logic [2:0]    r_dec;     // first decisive bit result, RES_NONE until then
    logic [2:0]    r_res;     // presented result flags
    logic [2:0]    w_final;
    logic          w_bgt;
    logic          w_blt;
    logic          w_inv;
    logic          w_last;
    logic          w_stop;

    assign w_inv  = r_sm & (r_idx == C_MSB_IDX);
    assign w_last = (r_idx == '0);

    cmp_bit u_cmp_bit (
        .a_bit   (r_a[r_idx]),
        .b_bit   (r_b[r_idx]),
        .msb_inv (w_inv),
        .gt      (w_bgt),
        .lt      (w_blt)
    );

    // Result as it stands after the current bit is folded in; an earlier
    // decision always takes precedence over lower-order bits.
    always_comb begin
        w_final = EQ;
        if (r_dec != RES_NONE) begin
            w_final = r_dec;
        end else if (w_bgt) begin
            w_final = GT;
        end else if (w_blt) begin
            w_final = LT;
        end
    end

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    // Any difference seen in RUN is the first one, since the run ends on it.
    assign w_stop = w_last | w_bgt | w_blt;
`else
    assign w_stop = w_last;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_next = RUN;
            RUN:     if (w_stop) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sm    <= 1'b0;
            r_idx   <= '0;
            r_dec   <= RES_NONE;
            r_res   <= RES_NONE;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_sm  <= signed_mode;
                        r_idx <= C_MSB_IDX;
                        r_dec <= RES_NONE;
                    end
                end
                RUN: begin
                    if ((r_dec == RES_NONE) && (w_bgt || w_blt)) begin
                        r_dec <= w_bgt ? GT : LT;
                    end
                    if (!w_last) begin
                        r_idx <= r_idx - 1'b1;
                    end
                    if (w_stop) begin
                        r_res <= w_final;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign gt   = r_res[2];
    assign eq   = r_res[1];
    assign lt   = r_res[0];

endmodule
`default_nettype wire

// File: tb/tb_serial_comparator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_comparator
//  Description : Self-checking bench for serial_comparator: W=8 vector table,
//                random vectors against a numeric reference, multi-cycle
//                corner sequences, and an exhaustive W=3 sweep.
//                Honours SERIAL_CMP_EARLY_EXIT_EN for expected latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_comparator;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start8, sm8, busy8, done8, gt8, eq8, lt8;
    logic [7:0] a8, b8;
    logic       start3, sm3, busy3, done3, gt3, eq3, lt3;
    logic [2:0] a3, b3;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] last8    = 3'b000;
    logic [2:0] last3    = 3'b000;

    always #5 clk = ~clk;

    serial_comparator #(.W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8),
        .signed_mode(sm8), .busy(busy8), .done(done8),
        .gt(gt8), .eq(eq8), .lt(lt8)
    );

    serial_comparator #(.W(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .start(start3), .a(a3), .b(b3),
        .signed_mode(sm3), .busy(busy3), .done(done3),
        .gt(gt3), .eq(eq3), .lt(lt3)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        bit         sm;
        logic [2:0] exp;   // {gt,eq,lt}
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: compare the operands as plain integers.
    function automatic logic [2:0] ref_cmp(input int w, input logic [7:0] a,
                                           input logic [7:0] b, input bit sm);
        int va;
        int vb;
        va = int'(a);
        vb = int'(b);
        if (sm && a[w-1]) va -= (1 << w);
        if (sm && b[w-1]) vb -= (1 << w);
        if (va > vb)  return 3'b100;
        if (va == vb) return 3'b010;
        return 3'b001;
    endfunction

    // Cycles from the start-sampling edge to the done cycle.
    function automatic int lat_model(input int w, input logic [7:0] a,
                                     input logic [7:0] b);
        int hi;
        hi = -1;
        for (int i = 0; i < w; i++) if (a[i] != b[i]) hi = i;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        return (hi < 0) ? w : (w - hi);
`else
        return (hi < 0) ? w : w;
`endif
    endfunction

    task automatic do_run(input bit w3, input logic [7:0] a, input logic [7:0] b,
                          input bit sm, input logic [2:0] exp, input int exp_lat,
                          input logic [2:0] prev);
        logic [2:0] fl;
        int         lat;
        @(negedge clk);
        if (w3) begin
            a3 = a[2:0]; b3 = b[2:0]; sm3 = sm; start3 = 1'b1;
        end else begin
            a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
        end
        @(posedge clk); #1;
        start3 = 1'b0;
        start8 = 1'b0;
        check("busy_rise", w3 ? busy3 : busy8, 1);
        check("held_flags", w3 ? {gt3, eq3, lt3} : {gt8, eq8, lt8}, prev);
        lat = -1;
        fl  = 3'b000;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (w3 ? done3 : done8) begin
                lat = n;
                fl  = w3 ? {gt3, eq3, lt3} : {gt8, eq8, lt8};
                break;
            end
        end
        check("flags", fl, exp);
        check("latency", lat, exp_lat);
        check("onehot", $countones(fl), 1);
        @(posedge clk); #1;
        check("done_pulse", w3 ? {done3, busy3} : {done8, busy8}, 0);
    endtask

    vec_t       vecs[11];
    logic [2:0] fl;
    logic [7:0] ra, rb;
    logic [2:0] re;
    int         lat;
    int         dcount;

    initial begin
        vecs[0]  = '{8'hA5, 8'h5A, 1'b0, 3'b100};
        vecs[1]  = '{8'h3C, 8'h3C, 1'b0, 3'b010};
        vecs[2]  = '{8'h3C, 8'h3C, 1'b1, 3'b010};
        vecs[3]  = '{8'h80, 8'h7F, 1'b1, 3'b001};
        vecs[4]  = '{8'h80, 8'h7F, 1'b0, 3'b100};
        vecs[5]  = '{8'hFF, 8'h01, 1'b1, 3'b001};
        vecs[6]  = '{8'hFF, 8'h01, 1'b0, 3'b100};
        vecs[7]  = '{8'h00, 8'h00, 1'b1, 3'b010};
        vecs[8]  = '{8'h01, 8'h02, 1'b0, 3'b001};
        vecs[9]  = '{8'h7F, 8'h80, 1'b1, 3'b100};
        vecs[10] = '{8'hFE, 8'hFF, 1'b1, 3'b001};

        reset_n = 1'b0;
        start8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0;
        start3 = 1'b0; a3 = '0; b3 = '0; sm3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out8", {busy8, done8, gt8, eq8, lt8}, 0);
        check("reset_out3", {busy3, done3, gt3, eq3, lt3}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            do_run(1'b0, vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].exp,
                   lat_model(8, vecs[i].a, vecs[i].b), last8);
            last8 = vecs[i].exp;
        end

        // Random vectors
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = (i % 5 == 0) ? ra : 8'($urandom);
            re = ref_cmp(8, ra, rb, bit'($urandom_range(0, 1)));
            // recompute with the same mode used for the run
            if (i % 2 == 0) begin
                re = ref_cmp(8, ra, rb, 1'b1);
                do_run(1'b0, ra, rb, 1'b1, re, lat_model(8, ra, rb), last8);
            end else begin
                re = ref_cmp(8, ra, rb, 1'b0);
                do_run(1'b0, ra, rb, 1'b0, re, lat_model(8, ra, rb), last8);
            end
            last8 = re;
        end

        // Inputs and start disturbed during RUN: latched operands rule
        @(negedge clk);
        a8 = 8'h3C; b8 = 8'h3D; sm8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        a8 = 8'hFF; b8 = 8'h00; sm8 = 1'b1;
        lat = -1; fl = 3'b000; dcount = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n == 2) start8 = 1'b1;
            if (n == 5) start8 = 1'b0;
            @(posedge clk); #1;
            if (done8) begin
                dcount++;
                lat = n;
                fl  = {gt8, eq8, lt8};
                break;
            end
        end
        check("latched_flags", fl, 3'b001);
        check("latched_latency", lat, 8);
        // start during the DONE cycle only: must be ignored
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("done_start_idle", {busy8, done8}, 0);
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (done8 || busy8) dcount++;
        end
        check("single_done", dcount, 1);
        last8 = 3'b001;

        // Reset mid-run at edge 3
        @(negedge clk);
        a8 = 8'h40; b8 = 8'h41; sm8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", {busy8, done8, gt8, eq8, lt8}, 0);
        dcount = 0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            if (done8 || busy8) dcount++;
        end
        check("no_done_in_reset", dcount, 0);
        @(negedge clk);
        reset_n = 1'b1;
        last8 = 3'b000;
        last3 = 3'b000;
        do_run(1'b0, 8'h40, 8'h41, 1'b0, 3'b001, lat_model(8, 8'h40, 8'h41), last8);
        last8 = 3'b001;

        // Exhaustive W=3 sweep
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 8; x++) begin
                for (int y = 0; y < 8; y++) begin
                    re = ref_cmp(3, 8'(x), 8'(y), bit'(s));
                    do_run(1'b1, 8'(x), 8'(y), bit'(s), re,
                           lat_model(3, 8'(x), 8'(y)), last3);
                    last3 = re;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
